i2c_slave_ctrl: RTL and testbench

I2C target (slave) byte engine for the peripheral side of the bus; it answers transfers issued by our I2C master byte/bit controller pair. It synchronises and filters SCL/SDA, detects START/STOP, matches a 7-bit own address, ACKs, and receives or transmits bytes. Bytes are exchanged with local logic through pulse and valid/ready handshakes. SCL is stretched while transmit data is not ready.

---
 rtl/i2c_slave_ctrl.sv | 178 +++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: I2C target byte engine (filtered scl_i/sda_i in, open-drain scl_oen/sda_oen out, rx pulse and tx valid/ready to local logic)
module i2c_slave_ctrl #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ena,
  input  logic [6:0] slv_addr,
  input  logic       ack_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rw,
  output logic       addr_match,
  output logic       start_det,
  output logic       stop_det,
  output logic       master_nack,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oen,
  output logic       sda_oen
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_LOAD, TX, TX_ACK} state_t;
  localparam logic [3:0] FL = 4'(FILTER_LEN - 1);
  state_t state;
  logic [1:0] scl_s, sda_s;
  logic [3:0] scl_c, sda_c, bit_cnt;
  logic scl_f, sda_f, scl_p, sda_p, ack_l;
  logic [7:0] shreg, byte_in;
  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_c = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c = scl_f & scl_p & ~sda_p & sda_f;
  assign byte_in = {shreg[6:0], sda_f};
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_c <= '0;
      sda_c <= '0;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
      scl_c <= (scl_s[1] == scl_f || scl_c == FL) ? 4'd0 : scl_c + 4'd1;
      sda_c <= (sda_s[1] == sda_f || sda_c == FL) ? 4'd0 : sda_c + 4'd1;
      scl_f <= (scl_s[1] != scl_f && scl_c == FL) ? scl_s[1] : scl_f;
      sda_f <= (sda_s[1] != sda_f && sda_c == FL) ? sda_s[1] : sda_f;
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn || !ena) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      ack_l <= 1'b0;
      scl_oen <= 1'b1;
      sda_oen <= 1'b1;
      tx_ready <= 1'b0;
      busy <= 1'b0;
      addr_match <= 1'b0;
      rx_valid <= 1'b0;
      start_det <= 1'b0;
      stop_det <= 1'b0;
      master_nack <= 1'b0;
      rx_data <= rstn ? rx_data : 8'h00;
      rw <= rstn & rw;
    end else begin
      addr_match <= 1'b0;
      rx_valid <= 1'b0;
      start_det <= 1'b0;
      stop_det <= 1'b0;
      master_nack <= 1'b0;
      if (start_c) begin
        state <= ADDR;
        bit_cnt <= '0;
        scl_oen <= 1'b1;
        sda_oen <= 1'b1;
        tx_ready <= 1'b0;
        start_det <= 1'b1;
        busy <= 1'b1;
      end else if (stop_c) begin
        state <= IDLE;
        scl_oen <= 1'b1;
        sda_oen <= 1'b1;
        tx_ready <= 1'b0;
        stop_det <= 1'b1;
        busy <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                addr_match <= byte_in[7:1] == slv_addr;
                rw <= (byte_in[7:1] == slv_addr) ? byte_in[0] : rw;
                state <= (byte_in[7:1] == slv_addr) ? ADDR : IDLE;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state <= ADDR_ACK;
              sda_oen <= 1'b0;
              bit_cnt <= '0;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              state <= rw ? TX_LOAD : RX;
              sda_oen <= 1'b1;
              scl_oen <= ~rw;
              tx_ready <= rw;
            end
          end
          RX: begin
            if (scl_rise) begin
              shreg <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                ack_l <= ack_en;
                rx_data <= byte_in;
                rx_valid <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state <= RX_ACK;
              sda_oen <= ~ack_l;
              bit_cnt <= '0;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              state <= RX;
              sda_oen <= 1'b1;
            end
          end
          TX_LOAD: begin
            if (tx_valid && tx_ready) begin
              state <= TX;
              shreg <= tx_data;
              sda_oen <= tx_data[7];
              tx_ready <= 1'b0;
              bit_cnt <= '0;
            end
          end
          TX: begin
            scl_oen <= 1'b1;
            if (scl_fall) begin
              state <= (bit_cnt == 4'd7) ? TX_ACK : TX;
              sda_oen <= (bit_cnt == 4'd7) ? 1'b1 : shreg[6];
              shreg <= {shreg[6:0], 1'b0};
              bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              master_nack <= sda_f;
              state <= sda_f ? IDLE : TX_ACK;
              bit_cnt <= 4'd8;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state <= TX_LOAD;
              scl_oen <= 1'b0;
              tx_ready <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: directed bench driving i2c_slave_ctrl through a wired-AND bus master model
module tb_i2c_slave_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ena = 1'b1;
  logic ack_en = 1'b1;
  logic tx_valid = 1'b0;
  logic [6:0] slv_addr = 7'h50;
  logic [7:0] tx_data = 8'h00;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, tx_ready, rw, addr_match, start_det, stop_det, master_nack, busy;
  logic scl_oen, sda_oen, scl_i, sda_i;
  int total = 0;
  int bad = 0;
  int am_n = 0, rxv_n = 0, sd_n = 0, pd_n = 0, mn_n = 0, sda_lo = 0, scl_lo = 0, both_n = 0;
  assign scl_i = scl_m & scl_oen;
  assign sda_i = sda_m & sda_oen;
  always #5 clk = ~clk;
  i2c_slave_ctrl #(.FILTER_LEN(3)) dut (
    .clk(clk), .rstn(rstn), .ena(ena), .slv_addr(slv_addr), .ack_en(ack_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rw(rw), .addr_match(addr_match), .start_det(start_det),
    .stop_det(stop_det), .master_nack(master_nack), .busy(busy),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oen(scl_oen), .sda_oen(sda_oen)
  );
  always @(negedge clk) begin
    if (addr_match === 1'b1) am_n++;
    if (rx_valid === 1'b1) rxv_n++;
    if (start_det === 1'b1) sd_n++;
    if (stop_det === 1'b1) pd_n++;
    if (master_nack === 1'b1) mn_n++;
    if (sda_oen === 1'b0) sda_lo++;
    if (scl_oen === 1'b0) scl_lo++;
    if (rx_valid === 1'b1 && tx_ready === 1'b1) both_n++;
  end
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bit_cyc(input logic b, input logic glitch, output logic r);
    int t;
    sda_m = b;
    wait_n(10);
    scl_m = 1'b1;
    t = 0;
    while (scl_i !== 1'b1 && t < 2000) begin
      wait_n(1);
      t++;
    end
    if (t >= 2000) begin
      total++;
      bad++;
      $display("FAIL scl_release_timeout scl_i=%b want=1", scl_i);
    end
    wait_n(10);
    if (glitch) begin
      scl_m = 1'b0;
      wait_n(2);
      scl_m = 1'b1;
    end
    r = sda_i;
    wait_n(10);
    scl_m = 1'b0;
    wait_n(10);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic glitch, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cyc(d[i], glitch && (i == 4), r);
    bit_cyc(1'b1, 1'b0, r);
    acked = ~r;
  endtask
  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_cyc(1'b1, 1'b0, r);
      d[i] = r;
    end
    bit_cyc(~mack, 1'b0, r);
  endtask
  task automatic feed(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    wait_n(1);
    tx_valid = 1'b0;
  endtask
  task automatic bus_start;
    sda_m = 1'b1;
    wait_n(10);
    scl_m = 1'b1;
    wait_n(20);
    sda_m = 1'b0;
    wait_n(20);
    scl_m = 1'b0;
    wait_n(10);
  endtask
  task automatic bus_stop;
    sda_m = 1'b0;
    wait_n(10);
    scl_m = 1'b1;
    wait_n(20);
    sda_m = 1'b1;
    wait_n(20);
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    wait_n(3);
    total++;
    if ({scl_oen, sda_oen} !== 2'b11) begin bad++; $display("FAIL reset_oen got=%b want=11", {scl_oen, sda_oen}); end
    total++;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    total++;
    if ({rx_valid, tx_ready, rw, busy, addr_match, start_det, stop_det, master_nack} !== 8'h00) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000000", {rx_valid, tx_ready, rw, busy, addr_match, start_det, stop_det, master_nack});
    end
    rstn = 1'b1;
    wait_n(20);
  endtask
  task automatic test_write;
    int a0, r0, p0, s0;
    logic ak;
    a0 = am_n; r0 = rxv_n; p0 = pd_n; s0 = sd_n;
    bus_start;
    total++;
    if (busy !== 1'b1 || sd_n - s0 != 1) begin bad++; $display("FAIL write_start busy=%b starts=%0d want busy=1 starts=1", busy, sd_n - s0); end
    send_byte(8'hA0, 1'b0, ak);
    total++;
    if (ak !== 1'b1) begin bad++; $display("FAIL write_addr_ack got=%b want=1", ak); end
    total++;
    if (rw !== 1'b0) begin bad++; $display("FAIL write_rw got=%b want=0", rw); end
    send_byte(8'h3C, 1'b0, ak);
    total++;
    if (ak !== 1'b1) begin bad++; $display("FAIL write_data_ack got=%b want=1", ak); end
    total++;
    if (rx_data !== 8'h3C) begin bad++; $display("FAIL write_rx_data got=%h want=3c", rx_data); end
    bus_stop;
    total++;
    if (am_n - a0 != 1) begin bad++; $display("FAIL write_addr_match got=%0d want=1", am_n - a0); end
    total++;
    if (rxv_n - r0 != 1) begin bad++; $display("FAIL write_rx_valid got=%0d want=1", rxv_n - r0); end
    total++;
    if (pd_n - p0 != 1 || busy !== 1'b0) begin bad++; $display("FAIL write_stop stops=%0d busy=%b want stops=1 busy=0", pd_n - p0, busy); end
  endtask
  task automatic test_mismatch;
    int a0, r0, d0, c0;
    logic ak;
    a0 = am_n; r0 = rxv_n; d0 = sda_lo; c0 = scl_lo;
    bus_start;
    send_byte(8'hA2, 1'b0, ak);
    total++;
    if (ak !== 1'b0) begin bad++; $display("FAIL mismatch_addr_ack got=%b want=0", ak); end
    send_byte(8'h3C, 1'b0, ak);
    total++;
    if (ak !== 1'b0) begin bad++; $display("FAIL mismatch_data_ack got=%b want=0", ak); end
    bus_stop;
    total++;
    if (am_n - a0 != 0 || rxv_n - r0 != 0) begin bad++; $display("FAIL mismatch_pulses am=%0d rxv=%0d want 0 0", am_n - a0, rxv_n - r0); end
    total++;
    if (sda_lo - d0 != 0 || scl_lo - c0 != 0) begin bad++; $display("FAIL mismatch_lines sda_lo=%0d scl_lo=%0d want 0 0", sda_lo - d0, scl_lo - c0); end
  endtask
  task automatic test_read;
    int m0;
    logic ak;
    logic [7:0] d;
    m0 = mn_n;
    bus_start;
    send_byte(8'hA1, 1'b0, ak);
    total++;
    if (ak !== 1'b1 || rw !== 1'b1) begin bad++; $display("FAIL read_addr ack=%b rw=%b want 1 1", ak, rw); end
    total++;
    if (tx_ready !== 1'b1 || scl_oen !== 1'b0) begin bad++; $display("FAIL read_stretch_start tx_ready=%b scl_oen=%b want 1 0", tx_ready, scl_oen); end
    wait_n(20);
    total++;
    if (scl_oen !== 1'b0 || scl_i !== 1'b0) begin bad++; $display("FAIL read_stretch_hold scl_oen=%b scl_i=%b want 0 0", scl_oen, scl_i); end
    feed(8'hA5);
    read_byte(1'b1, d);
    total++;
    if (d !== 8'hA5) begin bad++; $display("FAIL read_byte1 got=%h want=a5", d); end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL read_ready_again got=%b want=1", tx_ready); end
    feed(8'h3C);
    read_byte(1'b0, d);
    total++;
    if (d !== 8'h3C) begin bad++; $display("FAIL read_byte2 got=%h want=3c", d); end
    total++;
    if (mn_n - m0 != 1 || sda_oen !== 1'b1) begin bad++; $display("FAIL read_master_nack pulses=%0d sda_oen=%b want 1 1", mn_n - m0, sda_oen); end
    bus_stop;
  endtask
  task automatic test_nack_data;
    int r0;
    logic ak;
    r0 = rxv_n;
    bus_start;
    send_byte(8'hA0, 1'b0, ak);
    ack_en = 1'b0;
    send_byte(8'hFF, 1'b0, ak);
    ack_en = 1'b1;
    total++;
    if (ak !== 1'b0) begin bad++; $display("FAIL nack_data_ack got=%b want=0", ak); end
    total++;
    if (rxv_n - r0 != 1 || rx_data !== 8'hFF) begin bad++; $display("FAIL nack_data_rx rxv=%0d data=%h want 1 ff", rxv_n - r0, rx_data); end
    bus_stop;
  endtask
  task automatic test_back_to_back;
    int a0, s0, p0;
    logic ak;
    logic [7:0] d;
    a0 = am_n; s0 = sd_n; p0 = pd_n;
    bus_start;
    send_byte(8'hA0, 1'b0, ak);
    total++;
    if (rw !== 1'b0) begin bad++; $display("FAIL b2b_rw_write got=%b want=0", rw); end
    send_byte(8'h01, 1'b0, ak);
    total++;
    if (rx_data !== 8'h01) begin bad++; $display("FAIL b2b_rx_data got=%h want=01", rx_data); end
    bus_start;
    send_byte(8'hA1, 1'b0, ak);
    total++;
    if (rw !== 1'b1 || ak !== 1'b1) begin bad++; $display("FAIL b2b_rw_read rw=%b ack=%b want 1 1", rw, ak); end
    feed(8'h5A);
    read_byte(1'b0, d);
    total++;
    if (d !== 8'h5A) begin bad++; $display("FAIL b2b_read got=%h want=5a", d); end
    total++;
    if (busy !== 1'b1 || pd_n - p0 != 0) begin bad++; $display("FAIL b2b_busy busy=%b stops=%0d want 1 0", busy, pd_n - p0); end
    bus_stop;
    total++;
    if (sd_n - s0 != 2 || am_n - a0 != 2) begin bad++; $display("FAIL b2b_counts starts=%0d matches=%0d want 2 2", sd_n - s0, am_n - a0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b want=0", busy); end
  endtask
  task automatic test_glitch;
    int a0;
    logic ak;
    a0 = am_n;
    bus_start;
    send_byte(8'hA0, 1'b1, ak);
    total++;
    if (ak !== 1'b1 || am_n - a0 != 1) begin bad++; $display("FAIL glitch_addr ack=%b matches=%0d want 1 1", ak, am_n - a0); end
    bus_stop;
  endtask
  task automatic test_reset_tx;
    logic ak, r;
    bus_start;
    send_byte(8'hA1, 1'b0, ak);
    feed(8'hA5);
    for (int i = 0; i < 3; i++) bit_cyc(1'b1, 1'b0, r);
    total++;
    if (sda_oen !== 1'b0) begin bad++; $display("FAIL rst_tx_pre sda_oen=%b want=0", sda_oen); end
    rstn = 1'b0;
    wait_n(1);
    total++;
    if ({scl_oen, sda_oen, rx_valid, tx_ready, rw, busy, addr_match, start_det, stop_det, master_nack} !== 10'b11_0000_0000) begin
      bad++;
      $display("FAIL rst_tx_outputs got=%b want=1100000000", {scl_oen, sda_oen, rx_valid, tx_ready, rw, busy, addr_match, start_det, stop_det, master_nack});
    end
    total++;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_rx_data got=%h want=00", rx_data); end
    rstn = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_n(30);
  endtask
  initial begin
    test_reset;
    test_write;
    test_mismatch;
    test_read;
    test_nack_data;
    test_back_to_back;
    test_glitch;
    total++;
    if (both_n != 0) begin bad++; $display("FAIL rx_valid_tx_ready_overlap got=%0d want=0", both_n); end
    test_reset_tx;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
